// File: rtl/cache_pkg.sv
// Shared constants and types for the direct-mapped cache subsystem.
// Used by cache_memory, cache_controller and write_back_buffer.
package cache_pkg;
  localparam int ADDR_W      = 32;
  localparam int LINE_W      = 512;
  localparam int WORD_W      = 32;
  localparam int BEATS       = LINE_W / WORD_W;
  localparam int OFFSET_BITS = 6;
  localparam int TAG_LSB     = OFFSET_BITS;
  localparam int TAG_W       = ADDR_W - OFFSET_BITS;

  typedef enum logic {IDLE, BURST} drain_state_t;
endpackage

// File: rtl/wb_fifo.sv
// Line queue for the write-back buffer: circular storage with per-slot valid
// and a parallel tag lookup where the youngest matching slot wins.
module wb_fifo #(
  parameter int DEPTH  = 4,
  parameter int TAG_W  = 26,
  parameter int DATA_W = 512
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [TAG_W-1:0]         push_tag,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic [TAG_W-1:0]         head_tag,
  output logic [DATA_W-1:0]        head_data,
  input  logic [TAG_W-1:0]         lookup_tag,
  output logic                     lookup_hit,
  output logic [DATA_W-1:0]        lookup_data
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [TAG_W-1:0]  tags  [DEPTH];
  logic [DATA_W-1:0] lines [DEPTH];
  logic [DEPTH-1:0]  valid;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr, hit_idx, idx;

  assign full      = (count == CNT_W'(DEPTH));
  assign head_tag  = tags[rd_ptr];
  assign head_data = lines[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      tags[wr_ptr]  <= push_tag;
      lines[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two. The caller only
  // pushes when !full and pops when non-empty, so the two slots never collide.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (pop)  valid[rd_ptr] <= 1'b0;
      if (push) valid[wr_ptr] <= 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Scan oldest to youngest; a later match overrides, so the youngest wins.
  always_comb begin
    lookup_hit = 1'b0;
    hit_idx    = '0;
    idx        = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PTR_W'(i);
      if (valid[idx] && tags[idx] == lookup_tag) begin
        lookup_hit = 1'b1;
        hit_idx    = idx;
      end
    end
  end

  assign lookup_data = lookup_hit ? lines[hit_idx] : '0;
endmodule

// File: rtl/write_back_buffer.sv
// Queues evicted dirty lines and drains each to memory as a per-beat-acked
// write burst; exposes a combinational forwarding lookup for the miss path.
module write_back_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int LINE_W = 512,
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              evict_valid,
  output logic              evict_ready,
  input  logic [ADDR_W-1:0] evict_addr,
  input  logic [LINE_W-1:0] evict_data,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [WORD_W-1:0] mem_wr_data,
  input  logic              mem_wr_ack,
  input  logic [ADDR_W-1:0] lookup_addr,
  output logic              lookup_hit,
  output logic [LINE_W-1:0] lookup_data,
  output logic              empty
);
  import cache_pkg::drain_state_t;
  import cache_pkg::IDLE;
  import cache_pkg::BURST;
  import cache_pkg::OFFSET_BITS;

  localparam int BEATS  = LINE_W / WORD_W;
  localparam int BEAT_W = $clog2(BEATS);
  localparam int OFF_W  = OFFSET_BITS;
  localparam int TAG_W  = ADDR_W - OFF_W;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  drain_state_t      state;
  logic [BEAT_W-1:0] beat;
  logic [CNT_W-1:0]  count;
  logic              full, push, pop, last_beat;
  logic [TAG_W-1:0]  head_tag;
  logic [LINE_W-1:0] head_data;
  logic              unused_offset;

  assign unused_offset = ^{evict_addr[OFF_W-1:0], lookup_addr[OFF_W-1:0]};

  assign evict_ready = !full;
  assign push        = evict_valid && !full;
  assign last_beat   = (beat == BEAT_W'(BEATS - 1));
  assign pop         = (state == BURST) && mem_wr_ack && last_beat;

  wb_fifo #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(LINE_W)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_tag   (evict_addr[ADDR_W-1:OFF_W]),
    .push_data  (evict_data),
    .pop        (pop),
    .full       (full),
    .count      (count),
    .head_tag   (head_tag),
    .head_data  (head_data),
    .lookup_tag (lookup_addr[ADDR_W-1:OFF_W]),
    .lookup_hit (lookup_hit),
    .lookup_data(lookup_data)
  );

  // On the final ack, stay in BURST if anything remains (including a line
  // pushed on that same edge) so the next line starts without a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      beat  <= '0;
    end else begin
      case (state)
        IDLE: begin
          beat <= '0;
          if (count != '0) state <= BURST;
        end
        BURST: begin
          if (mem_wr_ack) begin
            if (last_beat) begin
              beat <= '0;
              if (count > CNT_W'(1) || push) state <= BURST;
              else                          state <= IDLE;
            end else begin
              beat <= beat + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_wr_en   = (state == BURST);
  assign mem_wr_addr = mem_wr_en ? {head_tag, beat, {(OFF_W-BEAT_W){1'b0}}} : '0;
  assign mem_wr_data = mem_wr_en ? head_data[int'(beat)*WORD_W +: WORD_W] : '0;
  assign empty       = (count == '0) && (state == IDLE);
endmodule
